// File: rtl/read_data_aligner.sv
// read_data_aligner: picks one element out of a raw SRAM read word and either
// widens it to the full bus (replicate / zero-extend / sign-extend) or packs
// successive narrow reads into one word. Single registered output stage with
// valid/ready on both sides.
module read_data_aligner #(
    parameter int DATA_W = 32,
    parameter int CONF_W = 3,
    localparam int LG_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CONF_W-1:0] conf,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LG_W-1:0]   in_addr,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LG_W:0]     out_count
);

    localparam logic [LG_W:0]       FULL_W    = (LG_W+1)'(DATA_W);
    localparam logic [CONF_W-1:0]   MAX_K     = CONF_W'(LG_W);
    localparam logic [1:0]          MODE_REP  = 2'b00;
    localparam logic [1:0]          MODE_SEXT = 2'b10;
    localparam logic [1:0]          MODE_PACK = 2'b11;

    typedef enum logic {OUT_IDLE, OUT_FULL} outState_t;

    outState_t          r_state;
    outState_t          w_stateNext;

    logic [DATA_W-1:0]  r_outData;
    logic [LG_W:0]      r_outCount;
    logic [LG_W-1:0]    r_cnt;
    logic [DATA_W-1:0]  r_acc;
    logic [CONF_W-1:0]  r_kLat;
    logic [1:0]         r_modeLat;

    logic [CONF_W-1:0]  w_kIn;
    logic [CONF_W-1:0]  w_k;
    logic [1:0]         w_mode;
    logic               w_accept;
    logic               w_isPack;
    logic               w_flushGo;
    logic [LG_W:0]      w_elemW;
    logic [LG_W-1:0]    w_signIdx;
    logic [LG_W-1:0]    w_idx;
    logic [LG_W:0]      w_bitOff;
    logic [DATA_W-1:0]  w_elemMask;
    logic [DATA_W-1:0]  w_elem;
    logic [DATA_W-1:0]  w_rep;
    logic [DATA_W-1:0]  w_sext;
    logic [LG_W:0]      w_slotOff;
    logic [DATA_W-1:0]  w_accNew;
    logic [LG_W:0]      w_groupN;
    logic [LG_W:0]      w_cntPlus1;
    logic               w_groupDone;
    logic               w_load;
    logic [DATA_W-1:0]  w_loadData;
    logic [LG_W:0]      w_loadCount;
    logic [LG_W-1:0]    w_cntNext;
    logic [DATA_W-1:0]  w_accNext;

    // Out-of-range conf collapses to full-width elements; mid-group beats use the latched config.
    assign w_kIn    = (conf > MAX_K) ? '0 : conf;
    assign w_k      = (r_cnt == '0) ? w_kIn : r_kLat;
    assign w_mode   = (r_cnt == '0) ? mode  : r_modeLat;
    assign w_isPack = (w_mode == MODE_PACK);

    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_flushGo = in_flush && in_ready && w_isPack;

    // Element geometry: E = DATA_W >> k, element index taken from the low k address bits.
    assign w_elemW    = FULL_W >> w_k;
    assign w_signIdx  = LG_W'(w_elemW - (LG_W+1)'(1));
    assign w_idx      = in_addr & ~({LG_W{1'b1}} << w_k);
    assign w_bitOff   = {1'b0, w_idx} * w_elemW;
    assign w_elemMask = {DATA_W{1'b1}} >> (FULL_W - w_elemW);
    assign w_elem     = (in_data >> w_bitOff) & w_elemMask;
    assign w_sext     = w_elem[w_signIdx] ? (w_elem | ~w_elemMask) : w_elem;

    // Pack slot position and group completion test.
    assign w_slotOff   = {1'b0, r_cnt} * w_elemW;
    assign w_accNew    = r_acc | (w_elem << w_slotOff);
    assign w_groupN    = (LG_W+1)'(1) << w_k;
    assign w_cntPlus1  = {1'b0, r_cnt} + (LG_W+1)'(1);
    assign w_groupDone = (w_cntPlus1 == w_groupN);

    // Replication: every output bit copies the element bit at the same position modulo E.
    always_comb begin
        w_rep = '0;
        for (int b = 0; b < DATA_W; b++) begin
            w_rep[b] = w_elem[LG_W'(b) & w_signIdx];
        end
    end

    // Decide what (if anything) loads the output register and how the pack state moves.
    always_comb begin
        w_load      = 1'b0;
        w_loadData  = w_accNew;
        w_loadCount = w_cntPlus1;
        w_cntNext   = r_cnt;
        w_accNext   = r_acc;
        if (w_accept) begin
            if (w_isPack) begin
                if (w_groupDone || w_flushGo) begin
                    w_load    = 1'b1;
                    w_cntNext = '0;
                    w_accNext = '0;
                end else begin
                    w_cntNext = w_cntPlus1[LG_W-1:0];
                    w_accNext = w_accNew;
                end
            end else begin
                w_load      = 1'b1;
                w_loadCount = (LG_W+1)'(1);
                case (w_mode)
                    MODE_REP:  w_loadData = w_rep;
                    MODE_SEXT: w_loadData = w_sext;
                    default:   w_loadData = w_elem;
                endcase
            end
        end else if (w_flushGo && (r_cnt != '0)) begin
            w_load      = 1'b1;
            w_loadData  = r_acc;
            w_loadCount = {1'b0, r_cnt};
            w_cntNext   = '0;
            w_accNext   = '0;
        end
    end

    // Output stage state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= OUT_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Output stage next state: fill on load, drain when the consumer takes the word.
    always_comb begin
        w_stateNext = r_state;
        if (w_load) begin
            w_stateNext = OUT_FULL;
        end else if (out_ready) begin
            w_stateNext = OUT_IDLE;
        end
    end

    // Output stage decode.
    always_comb begin
        out_valid = (r_state == OUT_FULL);
    end

    // Output data, pack accumulator and latched configuration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outData  <= '0;
            r_outCount <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_kLat     <= '0;
            r_modeLat  <= '0;
        end else begin
            if (w_load) begin
                r_outData  <= w_loadData;
                r_outCount <= w_loadCount;
            end
            r_cnt <= w_cntNext;
            r_acc <= w_accNext;
            if (w_accept && (r_cnt == '0)) begin
                r_kLat    <= w_kIn;
                r_modeLat <= mode;
            end
        end
    end

    assign out_data  = r_outData;
    assign out_count = r_outCount;

endmodule
